// File: rtl/fft32_pkg.sv
// Shared constants and decode helpers for the 32-point SDF FFT sequencer.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package fft32_pkg;
    localparam int N      = 32;
    localparam int LOG2N  = 5;
    localparam int NSTAGE = LOG2N;
    localparam int TW_W   = 4;

    // Feedback delay of stage s (1-based): 16, 8, 4, 2, 1.
    function automatic int stage_delay(input int s);
        return N >> s;
    endfunction

    // Cycle offset of stage s input relative to the FFT input; s = NSTAGE+1 gives the output.
    function automatic int stage_offset(input int s, input int lat);
        int off;
        off = 0;
        for (int i = 1; i < s; i++) begin
            off += stage_delay(i) + lat;
        end
        return off;
    endfunction

    function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    // W32 exponent for stage s: (k mod d) scaled by 2^(s-1), kept to the ROM address width.
    function automatic logic [TW_W-1:0] tw_decode(input logic [LOG2N-1:0] k, input int s, input int d);
        logic [LOG2N-1:0] m;
        m = k & LOG2N'(d - 1);
        m = m << (s - 1);
        return m[TW_W-1:0];
    endfunction
endpackage

// File: rtl/fft32_stage_seq.sv
// Per-stage sample counter with butterfly-select and twiddle-address decode.
// Latency: decode is combinational from the registered counter.
// Backpressure: none; counts every cycle vld is high.
module fft32_stage_seq
    import fft32_pkg::*;
#(
    parameter int S = 2,
    parameter int D = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    output logic [LOG2N-1:0] k,
    output logic             bf_sel,
    output logic [TW_W-1:0]  tw_addr
);
    always_ff @(posedge clk) begin
        if (rst) begin
            k <= '0;
        end else if (vld) begin
            k <= k + LOG2N'(1);
        end
    end

    assign bf_sel  = k[LOG2N-S];
    assign tw_addr = tw_decode(k, S, D);
endmodule

// File: rtl/fft32_seq_ctrl.sv
// Control sequencer for the 5-stage radix-2 DIF SDF FFT; tracks sample validity only.
// Latency: valid_o follows valid_i by 31+5*LAT cycles.
// Backpressure: none; a valid_i gap inside a frame raises a sticky err_o.
module fft32_seq_ctrl
    import fft32_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    output logic [NSTAGE-1:0]      stg_vld_o,
    output logic [NSTAGE-1:0]      bf_sel_o,
    output logic [TW_W*NSTAGE-1:0] tw_addr_o,
    output logic                   valid_o,
    output logic [LOG2N-1:0]       out_idx_o,
    output logic                   frame_done_o,
    output logic                   busy_o,
    output logic                   err_o
);
    localparam int VW = stage_offset(NSTAGE + 1, LAT);

    logic [VW-1:0]    vline;
    logic [LOG2N-1:0] in_cnt;
    logic [LOG2N-1:0] o_cnt;
    logic             err_q;
    // Stage counters are exported by each sequencer for debug visibility only.
    logic [LOG2N-1:0] stage_k_unused [2:NSTAGE];

    always_ff @(posedge clk) begin
        if (rst) begin
            vline  <= '0;
            in_cnt <= '0;
            o_cnt  <= '0;
            err_q  <= 1'b0;
        end else begin
            vline <= {vline[VW-2:0], valid_i};
            if (valid_i) begin
                in_cnt <= in_cnt + LOG2N'(1);
            end else if (in_cnt != '0) begin
                err_q <= 1'b1;
            end
            if (valid_o) begin
                o_cnt <= o_cnt + LOG2N'(1);
            end
        end
    end

    assign valid_o = vline[VW-1];

    // Stage 1 is indexed directly by the input counter.
    assign stg_vld_o[0]         = valid_i;
    assign bf_sel_o[0]          = in_cnt[LOG2N-1];
    assign tw_addr_o[TW_W-1:0]  = tw_decode(in_cnt, 1, stage_delay(1));

    for (genvar s = 2; s <= NSTAGE; s++) begin : g_stage
        localparam int LS = stage_offset(s, LAT);

        assign stg_vld_o[s-1] = vline[LS-1];

        fft32_stage_seq #(
            .S (s),
            .D (stage_delay(s))
        ) u_seq (
            .clk     (clk),
            .rst     (rst),
            .vld     (stg_vld_o[s-1]),
            .k       (stage_k_unused[s]),
            .bf_sel  (bf_sel_o[s-1]),
            .tw_addr (tw_addr_o[TW_W*s-1 -: TW_W])
        );
    end

    assign out_idx_o    = bitrev5(o_cnt);
    assign frame_done_o = valid_o & (o_cnt == LOG2N'(N - 1));
    assign busy_o       = (|vline) | (in_cnt != '0) | valid_o;
    assign err_o        = err_q;
endmodule

// File: tb/tb_fft32_seq_ctrl.sv
// Directed bench for fft32_seq_ctrl with an output scoreboard and a cycle model of the control outputs.
module tb_fft32_seq_ctrl;
    localparam int LAT     = 1;
    localparam int OUT_LAT = 36;
    localparam int L_TAP [5] = '{0, 17, 26, 31, 34};

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  stg_vld_o;
    logic [4:0]  bf_sel_o;
    logic [19:0] tw_addr_o;
    logic        valid_o;
    logic [4:0]  out_idx_o;
    logic        frame_done_o;
    logic        busy_o;
    logic        err_o;

    always #5 clk = ~clk;

    fft32_seq_ctrl #(.LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .stg_vld_o    (stg_vld_o),
        .bf_sel_o     (bf_sel_o),
        .tw_addr_o    (tw_addr_o),
        .valid_o      (valid_o),
        .out_idx_o    (out_idx_o),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [4:0] idx;
        logic       done;
    } sb_t;

    sb_t        sb[$];
    int         n_asrt = 0;
    int         n_fail = 0;
    bit         mon_en = 0;
    logic       hist[$];
    logic [4:0] m_k [5];
    logic       m_err;
    int         out_seq;
    bit         clr_pend;

    function automatic logic [4:0] brev(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

    function automatic logic tap(input int l);
        int c;
        c = hist.size();
        return (c >= l) ? hist[c-l] : 1'b0;
    endfunction

    function automatic logic [3:0] tw_model(input logic [4:0] k, input int s);
        int d;
        int t;
        d = 32 >> s;
        t = ((int'(k) % d) << (s - 1)) & 15;
        return 4'(t);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the edge, check at the falling edge, then advance the model.
    task automatic step(input logic v, input logic r);
        logic [4:0]  ev;
        logic [4:0]  ebf;
        logic [19:0] etw;
        logic        eb;
        sb_t         e;
        @(posedge clk);
        #1;
        if (clr_pend) begin
            sb.delete();
            clr_pend = 0;
        end
        rst     = r;
        valid_i = v;
        if (v && !r) begin
            e.cyc  = cyc + OUT_LAT;
            e.idx  = brev(5'(out_seq));
            e.done = (out_seq == 31);
            sb.push_back(e);
            out_seq = (out_seq + 1) % 32;
        end
        ev[0] = v;
        for (int s = 1; s < 5; s++) ev[s] = tap(L_TAP[s]);
        for (int s = 0; s < 5; s++) begin
            ebf[s]       = m_k[s][4-s];
            etw[4*s +: 4] = tw_model(m_k[s], s + 1);
        end
        eb = (m_k[0] != 5'd0);
        for (int i = 1; i <= OUT_LAT; i++) eb = eb | tap(i);
        @(negedge clk);
        chk("stg_vld", stg_vld_o, ev);
        chk("bf_sel", bf_sel_o, ebf);
        chk("tw_addr", tw_addr_o, etw);
        chk("busy", busy_o, eb);
        chk("err", err_o, m_err);
        if (r) begin
            hist.delete();
            for (int s = 0; s < 5; s++) m_k[s] = 5'd0;
            m_err    = 1'b0;
            out_seq  = 0;
            clr_pend = 1;
        end else begin
            for (int s = 1; s < 5; s++) if (ev[s]) m_k[s] = m_k[s] + 5'd1;
            if (v) m_k[0] = m_k[0] + 5'd1;
            else if (m_k[0] != 5'd0) m_err = 1'b1;
            hist.push_back(v);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (mon_en) begin
            if (valid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("valid_o_spurious", valid_o, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_cycle", cyc, e.cyc);
                    chk("out_idx", out_idx_o, e.idx);
                    chk("frame_done", frame_done_o, e.done);
                end
            end else begin
                chk("frame_done_idle", frame_done_o, 0);
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    chk("valid_o_missing", valid_o, 1);
                    e = sb.pop_front();
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        valid_i  = 1'b0;
        out_seq  = 0;
        m_err    = 1'b0;
        clr_pend = 0;
        for (int s = 0; s < 5; s++) m_k[s] = 5'd0;
        repeat (3) @(posedge clk);
        mon_en = 1;

        // Reset state
        step(1'b0, 1'b0);
        chk("rst_stg_vld", stg_vld_o, 0);
        chk("rst_bf_sel", bf_sel_o, 0);
        chk("rst_tw_addr", tw_addr_o, 0);
        chk("rst_valid_o", valid_o, 0);
        chk("rst_out_idx", out_idx_o, 0);
        chk("rst_frame_done", frame_done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        step(1'b0, 1'b0);

        // Single frame
        for (int r = 0; r < 72; r++) begin
            step(logic'(r < 32), 1'b0);
            if (r == 15) chk("s1_tw1_k15", tw_addr_o[3:0], 15);
            if (r == 16) chk("s1_bf1_rise", bf_sel_o[0], 1);
            if (r == 17) chk("s1_stg_17", stg_vld_o, 5'b00011);
            if (r == 22) chk("s2_k5_bf", bf_sel_o[1], 0);
            if (r == 22) chk("s2_k5_tw", tw_addr_o[7:4], 10);
            if (r == 24) chk("s2_k7_tw", tw_addr_o[7:4], 14);
            if (r == 26) chk("s1_stg_26", stg_vld_o, 5'b00111);
            if (r == 30) chk("s2_k13_bf", bf_sel_o[1], 1);
            if (r == 30) chk("s2_k13_tw", tw_addr_o[7:4], 10);
            if (r == 31) chk("s1_stg_31", stg_vld_o, 5'b01111);
            if (r == 34) chk("s1_stg_34", stg_vld_o, 5'b11110);
            if (r == 35) chk("s1_no_early_out", valid_o, 0);
            if (r == 36) chk("s1_first_out", valid_o, 1);
            if (r == 36) chk("s1_idx0", out_idx_o, 0);
            if (r == 37) chk("s1_idx1", out_idx_o, 16);
            if (r == 38) chk("s1_idx2", out_idx_o, 8);
            if (r == 67) chk("s1_done", frame_done_o, 1);
            if (r == 68) chk("s1_idle_busy", busy_o, 0);
        end

        // Back-to-back frames
        for (int r = 0; r < 104; r++) begin
            step(logic'(r < 64), 1'b0);
            if (r == 67) chk("b2b_done1", frame_done_o, 1);
            if (r == 68) chk("b2b_wrap_vld", valid_o, 1);
            if (r == 68) chk("b2b_wrap_idx", out_idx_o, 0);
            if (r == 69) chk("b2b_idx33", out_idx_o, 16);
            if (r == 99) chk("b2b_done2", frame_done_o, 1);
            if (r == 100) chk("b2b_idle_busy", busy_o, 0);
            if (r == 100) chk("b2b_err", err_o, 0);
        end

        // Gap between frames
        for (int r = 0; r < 113; r++) begin
            step(logic'(r < 32 || (r >= 41 && r < 73)), 1'b0);
            if (r == 76) chk("gap_no_out", valid_o, 0);
            if (r == 77) chk("gap_out2_vld", valid_o, 1);
            if (r == 77) chk("gap_out2_idx", out_idx_o, 0);
            if (r == 108) chk("gap_done2", frame_done_o, 1);
            if (r == 109) chk("gap_idle_busy", busy_o, 0);
            if (r == 112) chk("gap_err", err_o, 0);
        end

        // Mid-frame drop
        for (int r = 0; r < 116; r++) begin
            step(logic'(r != 10 && r < 75), 1'b0);
            if (r == 10) chk("drop_err_pre", err_o, 0);
            if (r == 11) chk("drop_err_set", err_o, 1);
            if (r == 115) chk("drop_err_held", err_o, 1);
        end

        // Reset clears the error, then reset in the middle of a frame
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("rst_err_clear", err_o, 0);
        for (int r = 0; r < 61; r++) begin
            step(logic'(r < 20), logic'(r == 20));
            if (r == 21) begin
                chk("mid_rst_stg", stg_vld_o, 0);
                chk("mid_rst_bf", bf_sel_o, 0);
                chk("mid_rst_tw", tw_addr_o, 0);
                chk("mid_rst_vld", valid_o, 0);
                chk("mid_rst_idx", out_idx_o, 0);
                chk("mid_rst_busy", busy_o, 0);
            end
        end

        // Fresh frame after reset keeps the single-frame timing
        for (int r = 0; r < 72; r++) begin
            step(logic'(r < 32), 1'b0);
            if (r == 36) chk("post_rst_vld", valid_o, 1);
            if (r == 36) chk("post_rst_idx", out_idx_o, 0);
            if (r == 67) chk("post_rst_done", frame_done_o, 1);
            if (r == 68) chk("post_rst_busy", busy_o, 0);
        end

        for (int i = 0; i < 50 && sb.size() > 0; i++) step(1'b0, 1'b0);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/fft32_seq_ctrl.md
Name: fft32_seq_ctrl

Overview:
Sequencer for the 32-point radix-2 DIF single-delay-feedback FFT pipeline (STAGE1..STAGE5, feedback delays 16/8/4/2/1).
- Tracks each sample as it flows through the pipeline.
- Drives each stage's butterfly/bypass select, twiddle ROM address and stage-valid.
- Produces the output valid, the bit-reversed output index, end-of-frame, busy and protocol-error flags.
- Sits beside the datapath. It carries no sample data.

Parameters:
LAT, 1, register latency added by each stage after its feedback delay (1..4)
N, 32, FFT length (fixed; LOG2N=5 from package)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
valid_i  in  1  input sample strobe (same cycle as data into STAGE1)
stg_vld_o  out  5  bit s-1: sample present at stage s input
bf_sel_o  out  5  bit s-1: 1=butterfly (add/sub) phase, 0=fill/bypass phase for stage s
tw_addr_o  out  20  4-bit W32 twiddle exponent per stage, stage s at [4s-1:4s-4]
valid_o  out  1  FFT output sample valid
out_idx_o  out  5  frequency bin of current output (bit-reversed order)
frame_done_o  out  1  one-cycle pulse with the last output of a frame
busy_o  out  1  any sample in flight or partial input frame
err_o  out  1  sticky: valid_i dropped mid-frame

Behaviour:
- Frame definition: 32 consecutive valid_i cycles. Frames may be back-to-back, and gaps are allowed only between frames.
- Input counter in_cnt[4:0]:
  - Increments on valid_i and wraps 31->0.
  - If valid_i=0 while in_cnt!=0, err_o is set next cycle and stays set until rst. in_cnt holds, and no recovery is attempted.
- Valid delay line:
  - vline is a shift register of 31+5*LAT bits that shifts every cycle, with valid_i as its input.
  - Stage input offsets: L1=0, L(s+1)=Ls+D(s)+LAT, with D=16,8,4,2,1. For LAT=1: 0,17,26,31,34. Output offset is L6=31+5*LAT.
  - stg_vld_o[0]=valid_i (combinational). stg_vld_o[s-1]=vline tap Ls.
  - valid_o is registered from tap L6.
- Per-stage counter k_s[4:0]:
  - Stage 1 uses in_cnt. Stages 2..5 use their own counters, which increment on stg_vld_o[s-1] and wrap at 31.
  - bf_sel_o[s-1]=k_s[5-s] (stage 1 uses bit4, stage 5 uses bit0). Combinational from the registered counter.
  - tw_addr for stage s = (k_s mod D(s)) << (s-1), truncated to 4 bits. Stage 5 is always 0.
  - The stage applies the twiddle only when bf_sel=0. Outputs in bf_sel=0 cycles are don't-care for the datapath.
- Output counter o_cnt[4:0]: increments on valid_o. out_idx_o = bitrev5(o_cnt).
- frame_done_o = valid_o & (o_cnt==31).
- busy_o = |vline | (in_cnt!=0) | valid_o.
- Latency: the first sample of a frame enters at cycle t, and the first output is at t+31+5*LAT.
- Reset values: every output 0, all counters 0, vline cleared.
- Reset mid-operation: all samples in flight are discarded. No valid_o follows until new input arrives.
- Simultaneous valid_i and frame_done_o are independent; no priority is needed.

Decomposition:
- Package fft32_pkg holds:
  - N=32, LOG2N=5
  - stage delay constants D[1..5]
  - function stage_offset(s, LAT)
  - function bitrev5
  - twiddle address width = 4
- Sub-module fft32_stage_seq (instantiated 4x for stages 2..5; stage 1 reuses in_cnt with the same decode):
  - Parameters: stage index S, D.
  - Inputs: vld.
  - Outputs: k counter, bf_sel, tw_addr.

Test Plan:
1. Single frame, LAT=1, valid_i high cycles 0-31:
   - bf_sel_o[0]=0 in cycles 0-15 and 1 in 16-31.
   - tw stage1 = k in cycles 0-15.
   - stg_vld_o rises at 17/26/31/34.
   - valid_o cycles 36-67, out_idx sequence 0,16,8,24,4,20...
   - frame_done_o at 67, busy_o=0 from cycle 68.
2. Stage 2 decode: at k_2=5, bf=0 and tw=10. At k_2=13, bf=1 and tw=10. At k_2=7, tw=14.
3. Back-to-back frames, valid_i cycles 0-63:
   - valid_o continuous 36-99, out_idx wraps 31->0 at cycle 68.
   - frame_done_o at 67 and 99. err_o stays 0.
4. Gap between frames (idle cycles 32-40, second frame 41-72): second-frame outputs cycles 77-108, err_o=0.
5. Mid-frame drop (valid_i low at sample 10): err_o=1 next cycle and held through further frames until rst.
6. rst asserted at cycle 20 of a frame: next cycle all outputs 0 and busy_o=0, with no valid_o afterwards. A new frame after reset meets scenario 1 timing.
